fetch_buffer: RTL and testbench

- Small FIFO between instruction fetch and decode; sits directly upstream of the immediate generator.
- Accepts {pc, inst} from fetch over a valid/ready handshake and pre-decodes the immediate format and signedness at enqueue.
- Presents fully registered {pc, inst, immSrc, immSign, illegal} to decode; decode wires inst, immSrc and immSign straight into the immediate generator.
- Supports a flush for branch or jump redirects.

---
 rtl/fetch_buffer_pkg.sv | 46 ++++
 rtl/fetch_buffer_if.sv | 35 +++
 rtl/fetch_buffer_inst_predecode.sv | 34 +++
 rtl/fetch_buffer.sv | 78 +++++++
 tb/tb_fetch_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer, the immediate generator and the decoder.
package fetch_buffer_pkg;

  // Immediate format codes consumed by the immediate generator
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_Z = 3'd5;

  // RISC-V base opcodes (inst[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int ENTRY_XLEN = 32;

  // Pre-decode result stored alongside each entry
  typedef struct packed {
    logic [2:0] immSrc;
    logic       immSign;
    logic       illegal;
  } pdec_t;

  localparam pdec_t PD_RESET = '{immSrc: IMM_I, immSign: 1'b1, illegal: 1'b0};

  // Full buffer entry as seen by decode
  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_XLEN-1:0] inst;
    logic [2:0]            immSrc;
    logic                  immSign;
    logic                  illegal;
  } entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the fetch buffer.
interface fetch_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            io_in_valid;
  logic            io_in_ready;
  logic [XLEN-1:0] io_in_pc;
  logic [XLEN-1:0] io_in_inst;
  logic            io_flush;
  logic            io_out_valid;
  logic            io_out_ready;
  logic [XLEN-1:0] io_out_pc;
  logic [XLEN-1:0] io_out_inst;
  logic [2:0]      io_out_immSrc;
  logic            io_out_immSign;
  logic            io_out_illegal;
  logic [CW-1:0]   io_count;

  // Fetch/decode environment side
  modport master (
    output io_in_valid, io_in_pc, io_in_inst, io_flush, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_pc, io_out_inst,
           io_out_immSrc, io_out_immSign, io_out_illegal, io_count
  );

  // Buffer side
  modport slave (
    input  io_in_valid, io_in_pc, io_in_inst, io_flush, io_out_ready,
    output io_in_ready, io_out_valid, io_out_pc, io_out_inst,
           io_out_immSrc, io_out_immSign, io_out_illegal, io_count
  );
endinterface

// File: rtl/fetch_buffer_inst_predecode.sv
// Enqueue-side pre-decode: immediate format, signedness and illegal-opcode flag.
module inst_predecode
  import fetch_buffer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst,
  output pdec_t           pd
);

  // Only opcode and funct3[2] matter; the rest of the word is ignored.
  logic unusedBits;
  assign unusedBits = ^inst;

  // Map opcode to immediate format; anything unrecognised is flagged illegal.
  always_comb begin
    pd = PD_RESET;
    if (inst[1:0] != 2'b11) begin
      pd.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_MISC, OP_OP: pd.immSrc = IMM_I;
        OP_STORE:           pd.immSrc = IMM_S;
        OP_BRANCH:          pd.immSrc = IMM_B;
        OP_LUI, OP_AUIPC:   pd.immSrc = IMM_U;
        OP_JAL:             pd.immSrc = IMM_J;
        OP_SYSTEM:          pd.immSrc = inst[14] ? IMM_Z : IMM_I;
        default:            pd.illegal = 1'b1;
      endcase
    end
    pd.immSign = (pd.immSrc != IMM_Z);
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode FIFO with enqueue-time immediate pre-decode and redirect flush.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic         clock,
  input  logic         reset,
  fetch_buffer_if.slave fb
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count;
  logic [AW-1:0]   head, tail;
  logic [XLEN-1:0] pcMem   [DEPTH];
  logic [XLEN-1:0] instMem [DEPTH];
  pdec_t           pdMem   [DEPTH];
  pdec_t           pdIn;
  logic            inReady, outValid, push, pop;

  inst_predecode #(.XLEN(XLEN)) u_predecode (
    .inst (fb.io_in_inst),
    .pd   (pdIn)
  );

  // Ready comes from occupancy alone, so a pop never frees a slot the same cycle.
  assign inReady  = (count < CW'(DEPTH));
  assign outValid = (count != '0);
  assign push     = fb.io_in_valid && inReady && !fb.io_flush;
  assign pop      = outValid && fb.io_out_ready && !fb.io_flush;

  assign fb.io_in_ready    = inReady;
  assign fb.io_out_valid   = outValid;
  assign fb.io_count       = count;
  // Head entry is always presented, valid or not; there is no empty bypass.
  assign fb.io_out_pc      = pcMem[head];
  assign fb.io_out_inst    = instMem[head];
  assign fb.io_out_immSrc  = pdMem[head].immSrc;
  assign fb.io_out_immSign = pdMem[head].immSign;
  assign fb.io_out_illegal = pdMem[head].illegal;

  // Occupancy and pointers; flush wins over any concurrent push or pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (fb.io_flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage; contents survive a flush and are only rewritten by pushes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]   <= '0;
        instMem[i] <= XLEN'(NOP);
        pdMem[i]   <= PD_RESET;
      end
    end else if (push) begin
      pcMem[tail]   <= fb.io_in_pc;
      instMem[tail] <= fb.io_in_inst;
      pdMem[tail]   <= pdIn;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized and directed checks of fetch_buffer against a queue-based model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic clock, reset;
  int total = 0, bad = 0;

  fetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fb ();

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .fb    (fb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  entry_t          mq[$];
  logic [31:0]     popped[$];
  logic            lastPush;
  logic [6:0]      ops [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0B};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Immediate format table straight from the opcode list: {immSrc, immSign, illegal}
  function automatic logic [4:0] refPd(input logic [31:0] i);
    if (i[1:0] != 2'b11) return {3'd0, 1'b1, 1'b1};
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h33: return {3'd0, 1'b1, 1'b0};
      7'h23:        return {3'd1, 1'b1, 1'b0};
      7'h63:        return {3'd2, 1'b1, 1'b0};
      7'h37, 7'h17: return {3'd3, 1'b1, 1'b0};
      7'h6F:        return {3'd4, 1'b1, 1'b0};
      7'h73:        return i[14] ? {3'd5, 1'b0, 1'b0} : {3'd0, 1'b1, 1'b0};
      default:      return {3'd0, 1'b1, 1'b1};
    endcase
  endfunction

  function automatic entry_t mkEntry(input logic [31:0] pc, input logic [31:0] inst);
    entry_t e;
    e.pc = pc;
    e.inst = inst;
    {e.immSrc, e.immSign, e.illegal} = refPd(inst);
    return e;
  endfunction

  task automatic checkState();
    chk("count", 64'(fb.io_count), 64'(mq.size()));
    chk("inReady", 64'(fb.io_in_ready), 64'(mq.size() < DEPTH));
    chk("outValid", 64'(fb.io_out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("outPc", 64'(fb.io_out_pc), 64'(mq[0].pc));
      chk("outInst", 64'(fb.io_out_inst), 64'(mq[0].inst));
      chk("outImm", 64'({fb.io_out_immSrc, fb.io_out_immSign, fb.io_out_illegal}),
          64'({mq[0].immSrc, mq[0].immSign, mq[0].illegal}));
    end
  endtask

  // One clock: drive, check at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl);
    logic doPush, doPop;
    fb.io_in_valid  = v;
    fb.io_in_pc     = pc;
    fb.io_in_inst   = inst;
    fb.io_out_ready = ordy;
    fb.io_flush     = fl;
    @(negedge clock);
    checkState();
    doPush = v && (mq.size() < DEPTH) && !fl;
    doPop  = (mq.size() != 0) && ordy && !fl;
    @(posedge clock);
    #1;
    if (fl) mq.delete();
    else begin
      if (doPop) begin
        popped.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (doPush) mq.push_back(mkEntry(pc, inst));
    end
    lastPush = doPush;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && mq.size() != 0; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drained", 64'(mq.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] sweep [6] = '{32'h00112623, 32'hFE0718E3, 32'h000802B7,
                               32'h0100006F, 32'h3400D073, 32'h00000000};
    logic [4:0]  sweepExp [6] = '{{3'd1, 1'b1, 1'b0}, {3'd2, 1'b1, 1'b0}, {3'd3, 1'b1, 1'b0},
                                  {3'd4, 1'b1, 1'b0}, {3'd5, 1'b0, 1'b0}, {3'd0, 1'b1, 1'b1}};
    logic        pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int sent;

    fb.io_in_valid = 0; fb.io_in_pc = 0; fb.io_in_inst = 0;
    fb.io_out_ready = 0; fb.io_flush = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(fb.io_out_valid), 64'd0);
    chk("rst_ready", 64'(fb.io_in_ready), 64'd1);
    chk("rst_count", 64'(fb.io_count), 64'd0);
    chk("rst_inst", 64'(fb.io_out_inst), 64'h13);
    chk("rst_pc", 64'(fb.io_out_pc), 64'd0);
    chk("rst_sign", 64'(fb.io_out_immSign), 64'd1);
    reset = 1'b1;

    // First push visible one edge later
    step(1'b1, 32'h80000000, 32'hFFF00093, 1'b0, 1'b0);
    chk("first_valid", 64'(fb.io_out_valid), 64'd1);
    chk("first_pc", 64'(fb.io_out_pc), 64'h80000000);
    chk("first_imm", 64'({fb.io_out_immSrc, fb.io_out_immSign, fb.io_out_illegal}),
        64'({3'd0, 1'b1, 1'b0}));

    // Pre-decode sweep with decode always ready
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h1000 + 32'(i * 4), sweep[i], 1'b1, 1'b0);
      chk($sformatf("sweep%0d", i),
          64'({fb.io_out_immSrc, fb.io_out_immSign, fb.io_out_illegal}), 64'(sweepExp[i]));
    end
    drain();

    // Full: two pushes stall, third valid refused, then ordered pops
    step(1'b1, 32'h2000, 32'h00000013, 1'b0, 1'b0);
    step(1'b1, 32'h2004, 32'h00112623, 1'b0, 1'b0);
    chk("full_count", 64'(fb.io_count), 64'd2);
    chk("full_ready", 64'(fb.io_in_ready), 64'd0);
    step(1'b1, 32'h2008, 32'h00000013, 1'b0, 1'b0);
    chk("full_refused", 64'(lastPush), 64'd0);
    popped.delete();
    step(1'b1, 32'h2008, 32'h00000013, 1'b1, 1'b0);
    chk("full_readyBack", 64'(fb.io_in_ready), 64'd1);
    chk("full_pop0", 64'(popped[0]), 64'h2000);
    drain();
    chk("full_pop1", 64'(popped[1]), 64'h2004);

    // Wrap: 7 entries with a toggling decode ready
    popped.delete();
    sent = 0;
    for (int k = 0; k < 60 && (sent < 7 || mq.size() != 0); k++) begin
      step(sent < 7, 32'(sent * 4), 32'h00000013, pat[k % 5], 1'b0);
      if (lastPush) sent++;
    end
    chk("wrap_len", 64'(popped.size()), 64'd7);
    for (int i = 0; i < popped.size(); i++) chk($sformatf("wrap%0d", i), 64'(popped[i]), 64'(i * 4));

    // Flush while full with a concurrent push
    popped.delete();
    step(1'b1, 32'h3000, 32'h00000013, 1'b0, 1'b0);
    step(1'b1, 32'h3004, 32'h00000013, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0000, 32'h00000013, 1'b1, 1'b1);
    chk("flush_count", 64'(fb.io_count), 64'd0);
    chk("flush_valid", 64'(fb.io_out_valid), 64'd0);
    chk("flush_ready", 64'(fb.io_in_ready), 64'd1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_nopop", 64'(popped.size()), 64'd0);

    // Asynchronous reset with one entry held
    step(1'b1, 32'h4000, 32'h00000013, 1'b0, 1'b0);
    chk("ar_pre", 64'(fb.io_out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", 64'(fb.io_out_valid), 64'd0);
    chk("ar_count", 64'(fb.io_count), 64'd0);
    mq.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    step(1'b1, 32'h4100, 32'h0100006F, 1'b0, 1'b0);
    chk("ar_after", 64'(fb.io_out_valid), 64'd1);
    chk("ar_afterPc", 64'(fb.io_out_pc), 64'h4100);
    drain();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(3) != 0) inst[6:0] = ops[$urandom_range(11)];
      step($urandom_range(1), $urandom, inst, $urandom_range(1), $urandom_range(15) == 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
